// File: rtl/mem_addr_sequencer.sv
// Multicycle memory address sequencer: steps instruction fetch, data access and
// exception entry through fixed-latency memory waits and drives the datapath strobes.
module mem_addr_sequencer #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       data_sel,
    input  logic       data_we,
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_div0,
    output logic [2:0] IorD,
    output logic       MemWR,
    output logic       IRWrite,
    output logic       EPCWrite,
    output logic       PCWrite,
    output logic       ExcLoad,
    output logic       busy,
    output logic       fetch_done,
    output logic       data_done,
    output logic       exc_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_WAIT,
        DATA_WAIT,
        EXC_SAVE,
        EXC_READ,
        EXC_LOAD
    } state_t;

    typedef struct packed {
        logic sel;
        logic we;
    } dacc_t;

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] pend, pend_nxt;
    logic [1:0] cause, cause_nxt;
    dacc_t      dacc, dacc_nxt;

    logic [2:0] exc_in;
    logic [2:0] exc_any;
    logic [1:0] cause_sel;
    logic [2:0] svc_mask;
    logic       last;

    // bit 0 = opcode, bit 1 = overflow, bit 2 = div0 (matches cause code order)
    assign exc_in  = {exc_div0, exc_overflow, exc_opcode};
    assign exc_any = pend | exc_in;
    assign last    = (cnt == LAST);

    always_comb begin
        cause_sel = 2'd3;
        svc_mask  = 3'b100;
        if (exc_any[0]) begin
            cause_sel = 2'd1;
            svc_mask  = 3'b001;
        end else if (exc_any[1]) begin
            cause_sel = 2'd2;
            svc_mask  = 3'b010;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            cause <= '0;
            dacc  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            cause <= cause_nxt;
            dacc  <= dacc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        pend_nxt  = pend | exc_in;
        cause_nxt = cause;
        dacc_nxt  = dacc;
        case (state)
            IDLE: begin
                if (|exc_any) begin
                    // The cause being serviced is dropped; other same-cycle pulses stay pending.
                    state_nxt = EXC_SAVE;
                    cause_nxt = cause_sel;
                    pend_nxt  = exc_in & ~svc_mask;
                end else if (data_req) begin
                    state_nxt = DATA_WAIT;
                    dacc_nxt  = '{sel: data_sel, we: data_we};
                end else if (fetch_req) begin
                    state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT, DATA_WAIT: begin
                if (last) state_nxt = IDLE;
                else      cnt_nxt   = cnt + 4'd1;
            end
            EXC_SAVE: state_nxt = EXC_READ;
            EXC_READ: begin
                if (last) state_nxt = EXC_LOAD;
                else      cnt_nxt   = cnt + 4'd1;
            end
            EXC_LOAD: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        IorD       = 3'b000;
        MemWR      = 1'b0;
        IRWrite    = 1'b0;
        EPCWrite   = 1'b0;
        PCWrite    = 1'b0;
        ExcLoad    = 1'b0;
        busy       = (state != IDLE);
        fetch_done = 1'b0;
        data_done  = 1'b0;
        exc_done   = 1'b0;
        case (state)
            FETCH_WAIT: begin
                IRWrite    = last;
                fetch_done = last;
            end
            DATA_WAIT: begin
                IorD      = {2'b10, dacc.sel};
                MemWR     = dacc.we;
                data_done = last;
            end
            EXC_SAVE: EPCWrite = 1'b1;
            EXC_READ: IorD = {1'b0, cause};
            EXC_LOAD: begin
                PCWrite  = 1'b1;
                ExcLoad  = 1'b1;
                exc_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Scoreboard bench: three sequencers (MEM_LAT 1, 2, 15) share stimulus; a transaction-level
// model queues each expected per-cycle output vector, a monitor pops and compares every cycle.
module tb_mem_addr_sequencer;

    localparam int N = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 15);
    endfunction

    typedef struct packed {
        logic [2:0] iord;
        logic       memwr;
        logic       irwrite;
        logic       epcwrite;
        logic       pcwrite;
        logic       excload;
        logic       busy;
        logic       fetch_done;
        logic       data_done;
        logic       exc_done;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fetch_req = 1'b0, data_req = 1'b0, data_sel = 1'b0, data_we = 1'b0;
    logic exc_opcode = 1'b0, exc_overflow = 1'b0, exc_div0 = 1'b0;

    vec_t obs [N];
    vec_t expq [N][$];
    logic [2:0] pend [N];
    int wait_n [N];
    int n_cmp = 0;
    int n_err = 0;
    int cyc_no = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [2:0] iord;
        logic memwr, irwrite, epcwrite, pcwrite, excload, busy, fdone, ddone, edone;
        mem_addr_sequencer #(.MEM_LAT(lat_of(g))) u_dut (
            .clk(clk), .reset(reset),
            .fetch_req(fetch_req), .data_req(data_req), .data_sel(data_sel), .data_we(data_we),
            .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
            .IorD(iord), .MemWR(memwr), .IRWrite(irwrite), .EPCWrite(epcwrite),
            .PCWrite(pcwrite), .ExcLoad(excload), .busy(busy),
            .fetch_done(fdone), .data_done(ddone), .exc_done(edone)
        );
        assign obs[g] = {iord, memwr, irwrite, epcwrite, pcwrite, excload, busy, fdone, ddone, edone};
    end

    function automatic vec_t mk(input logic [2:0] iord, input logic memwr, input logic irw,
                                input logic epc, input logic pcw, input logic fd,
                                input logic dd, input logic ed);
        vec_t v;
        v = '{iord: iord, memwr: memwr, irwrite: irw, epcwrite: epc, pcwrite: pcw,
              excload: pcw, busy: 1'b1, fetch_done: fd, data_done: dd, exc_done: ed};
        return v;
    endfunction

    // Called once per cycle while out of reset, after the inputs for the next edge are set.
    task automatic model_step();
        logic [2:0] ex;
        logic [2:0] eff;
        int lat;
        int c;
        ex = {exc_div0, exc_overflow, exc_opcode};
        for (int i = 0; i < N; i++) begin
            lat = lat_of(i);
            if (wait_n[i] > 0) begin
                wait_n[i]--;
                pend[i] = pend[i] | ex;
            end else begin
                eff = pend[i] | ex;
                if (eff != 3'b000) begin
                    c = eff[0] ? 1 : (eff[1] ? 2 : 3);
                    pend[i] = ex & ~(3'(1 << (c - 1)));
                    expq[i].push_back(mk(3'b000, 0, 0, 1, 0, 0, 0, 0));
                    for (int k = 0; k < lat; k++) expq[i].push_back(mk(3'(c), 0, 0, 0, 0, 0, 0, 0));
                    expq[i].push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 1));
                    wait_n[i] = lat + 2;
                end else if (data_req) begin
                    for (int k = 0; k < lat; k++)
                        expq[i].push_back(mk({2'b10, data_sel}, data_we, 0, 0, 0, 0, k == lat - 1, 0));
                    wait_n[i] = lat;
                end else if (fetch_req) begin
                    for (int k = 0; k < lat; k++)
                        expq[i].push_back(mk(3'b000, 0, k == lat - 1, 0, 0, k == lat - 1, 0, 0));
                    wait_n[i] = lat;
                end
            end
        end
    endtask

    task automatic cyc(input logic f, input logic d, input logic s, input logic w,
                       input logic [2:0] ex);
        @(negedge clk);
        fetch_req = f; data_req = d; data_sel = s; data_we = w;
        {exc_div0, exc_overflow, exc_opcode} = ex;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 3'b000);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        {fetch_req, data_req, data_sel, data_we, exc_div0, exc_overflow, exc_opcode} = '0;
        for (int i = 0; i < N; i++) begin
            expq[i].delete();
            pend[i] = '0;
            wait_n[i] = 0;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs[i] !== '0) begin
                n_err++;
                $display("FAIL reset_immediate lat=%0d: got %b want %b", lat_of(i), obs[i], 12'b0);
            end
        end
        repeat (n) @(negedge clk);
        reset = 1'b1;
        model_step();
    endtask

    always @(posedge clk) begin
        vec_t e;
        #1;
        cyc_no++;
        for (int i = 0; i < N; i++) begin
            e = (expq[i].size() > 0) ? expq[i].pop_front() : vec_t'(0);
            n_cmp++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL outputs lat=%0d cycle %0d: got %b want %b", lat_of(i), cyc_no, obs[i], e);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = '0;
            wait_n[i] = 0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_step();

        // single fetch, then idle
        cyc(1, 0, 0, 0, 3'b000);
        idle(20);
        // data write via ALUOut, data_sel toggled while the access is in flight
        cyc(0, 1, 1, 1, 3'b000);
        cyc(0, 1, 0, 1, 3'b000);
        cyc(0, 0, 0, 0, 3'b000);
        idle(20);
        // overflow and div0 together: serviced back to back, overflow first
        cyc(0, 0, 0, 0, 3'b110);
        idle(45);
        // opcode exception mid-fetch with fetch_req held
        cyc(1, 0, 0, 0, 3'b000);
        cyc(1, 0, 0, 0, 3'b001);
        for (int k = 0; k < 45; k++) cyc(1, 0, 0, 0, 3'b000);
        idle(20);
        // reset during the first data-wait cycle
        cyc(0, 1, 1, 1, 3'b000);
        do_reset(2);
        idle(5);

        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 19) == 0});
            end
        end
        idle(25);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (expq[i].size() != 0) begin
                n_err++;
                $display("FAIL drain lat=%0d: %0d expected cycles left, want 0", lat_of(i), expq[i].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
